// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and encodings for the hazard/forwarding control slice.
// The tag rd field is sized for the widest register address any instance uses.
package hazard_forward_unit_pkg;

  localparam int TAG_RD_W = 8;

  localparam logic [1:0] PC_SEL_HOLD   = 2'd0;
  localparam logic [1:0] PC_SEL_PLUS4  = 2'd1;
  localparam logic [1:0] PC_SEL_RESET  = 2'd2;
  localparam logic [1:0] PC_SEL_TARGET = 2'd3;

  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                regwr;
    logic                is_load;
  } tag_t;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/hazard_forward_unit_fwd_match.sv
// Compares one source register against the in-flight tags; the youngest
// matching producer wins and flags a load whose data is not yet available.
module fwd_match
  import hazard_forward_unit_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_LATENCY   = 1,
  parameter int SEL_W          = 2
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  rs_used,
  input  tag_t                  tags [NUM_FWD_STAGES],
  output logic [SEL_W-1:0]      sel,
  output logic                  load_hazard
);

  logic [TAG_RD_W-1:0] rs_ext;

  assign rs_ext = TAG_RD_W'(rs);

  // Walk oldest to youngest so the lowest matching stage overrides the rest.
  always_comb begin
    sel         = SEL_W'(FWD_REGFILE);
    load_hazard = 1'b0;
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (rs_used && (rs != '0) && tags[k].valid && tags[k].regwr &&
          (tags[k].rd == rs_ext)) begin
        sel         = SEL_W'(k + 1);
        load_hazard = tags[k].is_load && (k < LOAD_LATENCY);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline control: forwarding selects, load-use stall, branch flush, boot
// sequencing of the PC mux and saturating stall/flush counters.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_LATENCY   = 1,
  parameter int CNT_W          = 32,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          dec_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs,
  input  logic [NUM_SRC-1:0]            dec_rs_used,
  input  logic [REG_ADDR_W-1:0]         dec_rd,
  input  logic                          dec_regwr,
  input  logic                          dec_is_load,
  input  logic                          x_branch_taken,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall,
  output logic                          flush,
  output logic [1:0]                    pc_sel,
  output logic [CNT_W-1:0]              stall_count,
  output logic [CNT_W-1:0]              flush_count
);

  state_t             state;
  tag_t               tags [NUM_FWD_STAGES];
  tag_t               dec_tag;
  logic [NUM_SRC-1:0] src_hazard;
  logic               in_run;
  logic               enter;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .NUM_FWD_STAGES(NUM_FWD_STAGES),
      .REG_ADDR_W    (REG_ADDR_W),
      .LOAD_LATENCY  (LOAD_LATENCY),
      .SEL_W         (SEL_W)
    ) u_match (
      .rs         (dec_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used    (dec_rs_used[i]),
      .tags       (tags),
      .sel        (fwd_sel[i*SEL_W +: SEL_W]),
      .load_hazard(src_hazard[i])
    );
  end

  // A taken branch outranks a load-use stall: the stalled instruction is wrong-path.
  always_comb begin
    in_run = (state == ST_RUN);
    flush  = in_run && x_branch_taken;
    stall  = in_run && dec_valid && (|src_hazard) && !x_branch_taken;
    enter  = in_run && dec_valid && !stall && !flush;

    dec_tag         = '0;
    dec_tag.valid   = 1'b1;
    dec_tag.rd      = TAG_RD_W'(dec_rd);
    dec_tag.regwr   = dec_regwr;
    dec_tag.is_load = dec_is_load;

    if (!in_run)    pc_sel = PC_SEL_RESET;
    else if (flush) pc_sel = PC_SEL_TARGET;
    else if (stall) pc_sel = PC_SEL_HOLD;
    else            pc_sel = PC_SEL_PLUS4;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_BOOT;
      stall_count <= '0;
      flush_count <= '0;
      for (int k = 0; k < NUM_FWD_STAGES; k++) tags[k] <= '0;
    end else begin
      state   <= ST_RUN;
      tags[0] <= enter ? dec_tag : '0;
      for (int k = 1; k < NUM_FWD_STAGES; k++) tags[k] <= tags[k-1];
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed table-driven bench for hazard_forward_unit with hand-computed expectations.
module tb_hazard_forward_unit;

  logic        Clock;
  logic        Reset;
  logic        dec_valid;
  logic [9:0]  dec_rs;
  logic [1:0]  dec_rs_used;
  logic [4:0]  dec_rd;
  logic        dec_regwr;
  logic        dec_is_load;
  logic        x_branch_taken;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_sel;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  int checks;
  int passes;

  typedef struct {
    logic       valid;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       regwr;
    logic       load;
    logic       br;
    logic       chk_fwd;
    int         fwd0;
    int         fwd1;
    int         stl;
    int         fls;
    int         pc;
    int         scnt;
    int         fcnt;
  } vec_t;

  vec_t vecs [13];

  hazard_forward_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .dec_valid     (dec_valid),
    .dec_rs        (dec_rs),
    .dec_rs_used   (dec_rs_used),
    .dec_rd        (dec_rd),
    .dec_regwr     (dec_regwr),
    .dec_is_load   (dec_is_load),
    .x_branch_taken(x_branch_taken),
    .fwd_sel       (fwd_sel),
    .stall         (stall),
    .flush         (flush),
    .pc_sel        (pc_sel),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic vec_t mk(input logic v, input int rs0, input int rs1, input int used,
                              input int rd, input logic regwr, input logic load, input logic br,
                              input logic chk, input int f0, input int f1, input int stl,
                              input int fls, input int pc, input int scnt, input int fcnt);
    vec_t r;
    r.valid = v; r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(used);
    r.rd = 5'(rd); r.regwr = regwr; r.load = load; r.br = br; r.chk_fwd = chk;
    r.fwd0 = f0; r.fwd1 = f1; r.stl = stl; r.fls = fls; r.pc = pc;
    r.scnt = scnt; r.fcnt = fcnt;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input int rs0, input int rs1, input int used,
                               input int rd, input logic regwr, input logic load, input logic br);
    dec_valid      = v;
    dec_rs         = {5'(rs1), 5'(rs0)};
    dec_rs_used    = 2'(used);
    dec_rd         = 5'(rd);
    dec_regwr      = regwr;
    dec_is_load    = load;
    x_branch_taken = br;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".stall"}, int'(stall), 0);
    checkOutput({tag, ".flush"}, int'(flush), 0);
    checkOutput({tag, ".pc_sel"}, int'(pc_sel), 2);
    checkOutput({tag, ".fwd_sel"}, int'(fwd_sel), 0);
    checkOutput({tag, ".stall_count"}, int'(stall_count), 0);
    checkOutput({tag, ".flush_count"}, int'(flush_count), 0);
  endtask

  initial begin
    checks = 0;
    passes = 0;

    //            v   rs0 rs1 used rd  wr  ld  br  chk f0 f1 st fl pc sc fc
    vecs[0]  = mk(1,  0,  0,  0,   9,  1,  0,  0,  1,  0, 0, 0, 0, 2, 0, 0); // boot: x9 dropped
    vecs[1]  = mk(1,  9,  0,  1,   5,  1,  0,  0,  1,  0, 0, 0, 0, 1, 0, 0); // add x5
    vecs[2]  = mk(1,  5,  0,  1,   6,  1,  0,  0,  1,  1, 0, 0, 0, 1, 0, 0); // reads x5 from X
    vecs[3]  = mk(1,  6,  5,  3,   0,  0,  0,  0,  1,  1, 2, 0, 0, 1, 0, 0); // x5 from M
    vecs[4]  = mk(1,  0,  0,  0,   7,  1,  1,  0,  1,  0, 0, 0, 0, 1, 0, 0); // lw x7
    vecs[5]  = mk(1,  7,  0,  1,   8,  1,  0,  0,  0,  0, 0, 1, 0, 0, 0, 0); // load-use stall
    vecs[6]  = mk(1,  7,  0,  1,   8,  1,  0,  0,  1,  2, 0, 0, 0, 1, 1, 0); // replay, x7 from M
    vecs[7]  = mk(1,  8,  0,  1,  11,  1,  1,  0,  1,  1, 0, 0, 0, 1, 1, 0); // lw x11
    vecs[8]  = mk(1,  0, 11,  2,  12,  1,  0,  1,  1,  0, 1, 0, 1, 3, 1, 0); // flush beats stall
    vecs[9]  = mk(1, 12, 11,  3,   3,  1,  0,  0,  1,  0, 2, 0, 0, 1, 1, 1); // x12 killed
    vecs[10] = mk(1,  3,  0,  1,   3,  1,  0,  0,  1,  1, 0, 0, 0, 1, 1, 1); // second x3 producer
    vecs[11] = mk(1,  3,  0,  3,   0,  1,  0,  0,  1,  1, 0, 0, 0, 1, 1, 1); // youngest wins, x0
    vecs[12] = mk(1,  3,  0,  3,  13,  1,  1,  0,  1,  2, 0, 0, 0, 1, 1, 1); // pending rd=x0 ignored

    Reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checkResetValues("reset");
    Reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].valid, int'(vecs[i].rs0), int'(vecs[i].rs1), int'(vecs[i].used),
                    int'(vecs[i].rd), vecs[i].regwr, vecs[i].load, vecs[i].br);
      #1;
      checkOutput($sformatf("v%0d.stall", i), int'(stall), vecs[i].stl);
      checkOutput($sformatf("v%0d.flush", i), int'(flush), vecs[i].fls);
      checkOutput($sformatf("v%0d.pc_sel", i), int'(pc_sel), vecs[i].pc);
      checkOutput($sformatf("v%0d.stall_count", i), int'(stall_count), vecs[i].scnt);
      checkOutput($sformatf("v%0d.flush_count", i), int'(flush_count), vecs[i].fcnt);
      if (vecs[i].chk_fwd) begin
        checkOutput($sformatf("v%0d.fwd0", i), int'(fwd_sel[1:0]), vecs[i].fwd0);
        checkOutput($sformatf("v%0d.fwd1", i), int'(fwd_sel[3:2]), vecs[i].fwd1);
      end
      @(posedge Clock);
      @(negedge Clock);
    end

    // Consumer of lw x13 stalls, then reset lands in the middle of the stall.
    applyStimulus(1, 13, 0, 1, 14, 1, 0, 0);
    #1;
    checkOutput("midstall.stall", int'(stall), 1);
    checkOutput("midstall.pc_sel", int'(pc_sel), 0);
    Reset = 1'b0;
    #1;
    checkResetValues("async_reset");
    @(posedge Clock);
    @(negedge Clock);
    checkResetValues("held_reset");
    Reset = 1'b1;
    #1;
    checkOutput("post_reset_boot.pc_sel", int'(pc_sel), 2);
    checkOutput("post_reset_boot.stall", int'(stall), 0);
    @(posedge Clock);
    @(negedge Clock);
    #1;
    checkOutput("post_reset_run.pc_sel", int'(pc_sel), 1);
    checkOutput("post_reset_run.stall", int'(stall), 0);
    checkOutput("post_reset_run.fwd0", int'(fwd_sel[1:0]), 0);
    checkOutput("post_reset_run.stall_count", int'(stall_count), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
